// File: rtl/mdu_ctrl_if.sv
// Pipeline-side bundle for the multiply/divide sequencer: E-stage issue, D-stage
// hazard query, and the HI/LO view. The pipeline is the master, the MDU the slave.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rd_hi;
    logic        d_md_use;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    modport master (
        output start, op, rs_val, rt_val, rd_hi, d_md_use,
        input  busy, stall_md, hi, lo, md_out
    );

    modport slave (
        input  start, op, rs_val, rt_val, rd_hi, d_md_use,
        output busy, stall_md, hi, lo, md_out
    );
endinterface

// File: rtl/mdu_ctrl.sv
// MIPS multiply/divide sequencer: owns HI/LO, models fixed mult/div latency with a
// down-counter, and asks the D stage to stall any HI/LO user while an op is in flight.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1) + 1;
    localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [1:0]       op_reg,    op_next;
    logic [31:0]      a_reg,     a_next;
    logic [31:0]      b_reg,     b_next;
    logic [31:0]      hi_reg,    hi_next;
    logic [31:0]      lo_reg,    lo_next;

    // Arithmetic always works on the latched operands, never the live buses.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] b_sdiv;
    logic [31:0] b_udiv;
    logic [31:0] quot_s, rem_s;
    logic [31:0] quot_u, rem_u;

    assign prod_s = $signed({{32{a_reg[31]}}, a_reg}) * $signed({{32{b_reg[31]}}, b_reg});
    assign prod_u = {32'd0, a_reg} * {32'd0, b_reg};

    // A zero divisor leaves HI/LO untouched, so the divider only needs a harmless
    // stand-in. For 0x80000000 / -1, dividing by 1 yields exactly the wrapped answer.
    assign div_zero = (b_reg == 32'd0);
    assign div_ovf  = (a_reg == 32'h8000_0000) && (b_reg == 32'hFFFF_FFFF);
    assign b_sdiv   = (div_zero || div_ovf) ? 32'd1 : b_reg;
    assign b_udiv   = div_zero ? 32'd1 : b_reg;

    assign quot_s = $signed(a_reg) / $signed(b_sdiv);
    assign rem_s  = $signed(a_reg) % $signed(b_sdiv);
    assign quot_u = a_reg / b_udiv;
    assign rem_u  = a_reg % b_udiv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            op_next    = bus.op[1:0];
                            a_next     = bus.rs_val;
                            b_next     = bus.rt_val;
                            cnt_next   = bus.op[1] ? DIV_N : MULT_N;
                            state_next = BUSY;
                        end
                        3'd4:    hi_next = bus.rs_val;
                        3'd5:    lo_next = bus.rs_val;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                // New starts are ignored here; the D-stage stall keeps them out anyway.
                cnt_next = cnt_reg - CNT_ONE;
                if (cnt_reg == CNT_ONE) begin
                    state_next = IDLE;
                    case (op_reg)
                        2'd0: {hi_next, lo_next} = prod_s;
                        2'd1: {hi_next, lo_next} = prod_u;
                        2'd2: begin
                            if (!div_zero) begin
                                lo_next = quot_s;
                                hi_next = rem_s;
                            end
                        end
                        default: begin
                            if (!div_zero) begin
                                lo_next = quot_u;
                                hi_next = rem_u;
                            end
                        end
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy     = (state_reg == BUSY);
    // The issue-cycle term catches the D-stage user before busy has risen.
    assign bus.stall_md = bus.d_md_use & (bus.busy | (bus.start & (bus.op <= 3'd3)));
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    assign bus.md_out   = bus.rd_hi ? hi_reg : lo_reg;

endmodule
